titan_prefetch_if: RTL and testbench
====================================

Name: titan_prefetch_if

Overview:
- Parametrised instruction-fetch front end for the Titan core.
- Acts as a Wishbone classic master on the instruction port and keeps a configurable-depth prefetch FIFO of {pc, instruction, fault} entries.
- Supports pipeline redirect with discard of an in-flight response, and blocks further fetching after a bus error.
- Sits between the instruction bus and the decode stage; the decode stage pulls entries with a valid/ready handshake.

Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-low reset.
- iwbm_addr_o  out  32  fetch address.
- iwbm_cyc_o  out  1  bus cycle.
- iwbm_stb_o  out  1  strobe.
- iwbm_dat_i  in  32  read data.
- iwbm_ack_i  in  1  transfer acknowledge.
- iwbm_err_i  in  1  transfer error.
- redirect_i  in  1  flush and restart at redirect_addr_i (branch, jump or trap).
- redirect_addr_i  in  32  new fetch PC.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts the head.
- out_pc_o  out  32  PC of the head entry.
- out_instr_o  out  32  instruction of the head entry.
- out_fault_o  out  1  head entry carries an instruction access fault.
- out_exc_data_o  out  32  faulting address, valid when out_fault_o=1.
- empty_o  out  1  FIFO count is 0.

Behaviour:
- Reset, while rst_i=0 on a clock edge:
  - state IDLE; fetch_pc=RESET_ADDR; FIFO count 0.
  - iwbm_cyc_o=iwbm_stb_o=0; iwbm_addr_o=RESET_ADDR.
  - out_valid_o=0; out_pc_o/out_instr_o/out_exc_data_o=0; out_fault_o=0; empty_o=1.
  - Reset during an open bus cycle drops cyc/stb at that edge; the late ack is ignored.
- At most one outstanding transfer. cyc and stb are registered, equal, and held until ack or err.
- State machine:
  - IDLE: if no redirect_i and count<DEPTH, go to REQ next cycle with cyc=stb=1 and addr=fetch_pc.
  - REQ, on ack:
    - Push {fetch_pc, dat_i, 0}; fetch_pc+=PC_STEP.
    - Go to IDLE. cyc drops for one cycle, so the back-to-back issue rate is one fetch per 2 cycles plus ack latency.
  - REQ, on err:
    - Push {fetch_pc, 32'h0, 1}, with exc_data=fetch_pc.
    - Go to FAULT.
  - REQ, on redirect_i without ack/err: go to DISCARD; cyc/stb stay high.
  - DISCARD: on ack or err, drop the data, deassert cyc/stb and go to IDLE. No push.
  - FAULT: no fetch issued. Leave only via redirect_i, to IDLE.
- Redirect:
  - At the edge where redirect_i=1, the FIFO is emptied: out_valid_o=0 next cycle.
  - fetch_pc<=redirect_addr_i.
  - Any pop in that cycle is ignored.
  - Redirect in the same cycle as ack/err: the response is discarded and the state goes to IDLE, not DISCARD.
  - Redirect in IDLE or FAULT: go to IDLE; the next issue is no earlier than the following cycle.
- FIFO:
  - Registered; an entry pushed at edge N is visible at out_* after edge N.
  - Pop when out_valid_o & out_ready_i.
  - Push and pop in the same cycle: count unchanged.
  - Full (count=DEPTH): no issue.
  - Issue is gated on count<DEPTH at issue time. With one outstanding transfer and pops never raising count, the ack can never overflow the FIFO.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - out_* hold stable while out_valid_o=1 and out_ready_i=0.
- Address arithmetic is modulo 2^32; fetch_pc wraps from 32'hFFFF_FFFC to 0.
- iwbm_addr_o is defined only while cyc=1. It holds the last issued address otherwise.

Optional Feature:
- Macro: TITAN_PREFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and an ack arrives with no redirect_i, out_* present the incoming data combinationally in the same cycle with out_valid_o=1.
  - If out_ready_i=1 that cycle, the entry is consumed and not written.
  - Otherwise it is written as normal.
  - Err responses never bypass.
- Undefined: minimum response-to-consumer latency is one cycle, as described above.

Test Plan:
- Reset release, ack one cycle after each stb, out_ready_i=1 -> addresses 0x0, 0x4, 0x8 issued; out_pc_o sequence 0x0, 0x4, 0x8 with the matching out_instr_o; out_fault_o=0 throughout.
- DEPTH=4, out_ready_i=0 -> exactly 4 transfers complete, count=4, cyc stays 0. Raise out_ready_i for 1 cycle -> one pop, then one new fetch at 0x10.
- Hold ack for 3 cycles, pulse redirect_i with addr 0x100 while the transfer is pending -> cyc held until ack, data 0xDEADBEEF discarded, FIFO empty, next fetch at 0x100.
- Ack and redirect_i to 0x200 in the same cycle -> no push; next address 0x200.
- err_i on fetch at 0x40 -> entry with out_fault_o=1, out_exc_data_o=0x40, out_instr_o=0; no further cyc until redirect_i to 0x80, then a fetch at 0x80.
- Drive rst_i=0 mid-transfer with cyc=1 -> cyc/stb=0 at that edge, out_valid_o=0; after release, first fetch at RESET_ADDR and the late ack is ignored.

Source files
------------

// File: rtl/titan_prefetch_if_if.sv
// Titan instruction-port Wishbone classic bundle.
// Master side is the prefetch unit, slave side is the instruction bus.
interface titan_prefetch_if_if;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o;
  logic        iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i;
  logic        iwbm_err_i;

  modport master (
    output iwbm_addr_o,
    output iwbm_cyc_o,
    output iwbm_stb_o,
    input  iwbm_dat_i,
    input  iwbm_ack_i,
    input  iwbm_err_i
  );

  modport slave (
    input  iwbm_addr_o,
    input  iwbm_cyc_o,
    input  iwbm_stb_o,
    output iwbm_dat_i,
    output iwbm_ack_i,
    output iwbm_err_i
  );
endinterface

// File: rtl/titan_prefetch_if.sv
// Titan fetch front end: Wishbone master plus {pc, instr, fault} FIFO.
// Define TITAN_PREFETCH_BYPASS_EN to forward an ack to an empty FIFO head.
module titan_prefetch_if #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  titan_prefetch_if_if.master iwbm,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        out_fault_o,
  output logic [31:0] out_exc_data_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    FAULT
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          cyc_q, cyc_d;
  logic          resp;
  logic          push;
  logic          wr;
  logic          pop;
  entry_t        push_e;
  entry_t        head;
  logic          head_valid;
  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;

  assign resp = iwbm.iwbm_ack_i | iwbm.iwbm_err_i;

  // Fetch FSM: issue, response handling, redirect and fault lockout
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    cyc_d   = cyc_q;
    push    = 1'b0;
    push_e  = '{pc: pc_q, instr: 32'h0, fault: 1'b0};
    unique case (state_q)
      IDLE: begin
        if (redirect_i) begin
          pc_d = redirect_addr_i;
        end else if (cnt_q < FULL) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      REQ: begin
        if (resp) begin
          cyc_d = 1'b0;
          if (redirect_i) begin
            state_d = IDLE;
            pc_d    = redirect_addr_i;
          end else if (iwbm.iwbm_ack_i) begin
            push         = 1'b1;
            push_e.instr = iwbm.iwbm_dat_i;
            pc_d         = pc_q + PC_STEP;
            state_d      = IDLE;
          end else begin
            push         = 1'b1;
            push_e.fault = 1'b1;
            state_d      = FAULT;
          end
        end else if (redirect_i) begin
          state_d = DISCARD;
          pc_d    = redirect_addr_i;
        end
      end
      DISCARD: begin
        if (redirect_i) begin
          pc_d = redirect_addr_i;
        end
        if (resp) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (redirect_i) begin
          state_d = IDLE;
          pc_d    = redirect_addr_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and bus registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cyc_q   <= cyc_d;
    end
  end

  assign iwbm.iwbm_addr_o = addr_q;
  assign iwbm.iwbm_cyc_o  = cyc_q;
  assign iwbm.iwbm_stb_o  = cyc_q;

`ifdef TITAN_PREFETCH_BYPASS_EN
  logic byp;
  assign byp        = (cnt_q == '0) && push && !push_e.fault;
  assign head_valid = (cnt_q != '0) || byp;
  assign head       = (cnt_q != '0) ? mem[rd_q] : push_e;
  assign wr         = push && !(byp && out_ready_i);
`else
  assign head_valid = (cnt_q != '0);
  assign head       = mem[rd_q];
  assign wr         = push;
`endif

  assign pop = (cnt_q != '0) && out_ready_i && !redirect_i;

  // FIFO pointers and occupancy; redirect empties the queue
  always_ff @(posedge clk_i) begin
    if (!rst_i || redirect_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        wr_q <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      if (wr && !pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop && !wr) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // FIFO storage; no reset needed, head is masked while empty
  always_ff @(posedge clk_i) begin
    if (rst_i && wr) begin
      mem[wr_q] <= push_e;
    end
  end

  assign out_valid_o    = head_valid;
  assign out_pc_o       = head_valid ? head.pc : 32'h0;
  assign out_instr_o    = head_valid ? head.instr : 32'h0;
  assign out_fault_o    = head_valid && head.fault;
  assign out_exc_data_o = out_fault_o ? head.pc : 32'h0;
  assign empty_o        = (cnt_q == '0);

endmodule

// File: tb/tb_titan_prefetch_if.sv
// Bench for titan_prefetch_if: scoreboard on the consumer side,
// directed bus/redirect/reset scenarios on the producer side.
module tb_titan_prefetch_if;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic        out_fault_o;
  logic [31:0] out_exc_data_o;
  logic        empty_o;

  always #5 clk = ~clk;

  titan_prefetch_if_if bus ();

  titan_prefetch_if dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .iwbm           (bus),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_pc_o       (out_pc_o),
    .out_instr_o    (out_instr_o),
    .out_fault_o    (out_fault_o),
    .out_exc_data_o (out_exc_data_o),
    .empty_o        (empty_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] exc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          resp_en = 1'b1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_dat = 32'hDEAD_BEEF;

  function automatic logic [31:0] dword(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (addr_log.size() > i) ? addr_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input logic v, input string name);
    int n;
    n = 0;
    while (bus.iwbm_cyc_o !== v && n < 100) begin
      step();
      n++;
    end
    check(name, {31'h0, bus.iwbm_cyc_o}, {31'h0, v});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect_addr_i = a;
    redirect_i      = 1'b1;
    step();
    redirect_i      = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr,
                          input logic fault, input logic [31:0] exc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.fault = fault;
    e.exc   = exc;
    exp_q.push_back(e);
  endtask

  // Bus slave: acks each new cycle after lat wait cycles
  initial begin
    int cnt;
    cnt = -1;
    bus.iwbm_ack_i = 1'b0;
    bus.iwbm_err_i = 1'b0;
    bus.iwbm_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        cnt = -1;
        continue;
      end
      bus.iwbm_ack_i = 1'b0;
      if (rst_i !== 1'b1 || bus.iwbm_cyc_o !== 1'b1) begin
        cnt = -1;
        continue;
      end
      if (cnt < 0) begin
        cnt = lat;
        addr_log.push_back(bus.iwbm_addr_o);
      end
      if (cnt == 0) begin
        bus.iwbm_dat_i = ovr_en ? ovr_dat : dword(bus.iwbm_addr_o);
        bus.iwbm_ack_i = 1'b1;
        cnt = -1;
      end else begin
        cnt--;
      end
    end
  end

  // Scoreboard monitor: every accepted head entry is checked in order
  always @(negedge clk) begin
    if (rst_i === 1'b1 && out_valid_o === 1'b1 &&
        out_ready_i === 1'b1 && redirect_i !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h want none", out_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", out_pc_o, e.pc);
        check("pop_instr", out_instr_o, e.instr);
        check("pop_fault", {31'h0, out_fault_o}, {31'h0, e.fault});
        check("pop_exc", out_exc_data_o, e.exc);
      end
    end
  end

  initial begin
    rst_i           = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    out_ready_i     = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_cyc", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, bus.iwbm_stb_o}, 32'h0);
    check("rst_addr", bus.iwbm_addr_o, 32'h0);
    check("rst_valid", {31'h0, out_valid_o}, 32'h0);
    check("rst_pc", out_pc_o, 32'h0);
    check("rst_instr", out_instr_o, 32'h0);
    check("rst_fault", {31'h0, out_fault_o}, 32'h0);
    check("rst_exc", out_exc_data_o, 32'h0);
    check("rst_empty", {31'h0, empty_o}, 32'h1);

    // sequential fetch with consumer always ready
    push_exp(32'h0, 32'hA5A5_0000, 1'b0, 32'h0);
    push_exp(32'h4, 32'hA5A5_0004, 1'b0, 32'h0);
    push_exp(32'h8, 32'hA5A5_0008, 1'b0, 32'h0);
    out_ready_i = 1'b1;
    rst_i       = 1'b1;
    wait_drain("t1_drain");
    out_ready_i = 1'b0;
    check("t1_addr0", log_at(0), 32'h0);
    check("t1_addr1", log_at(1), 32'h4);
    check("t1_addr2", log_at(2), 32'h8);

    // fill to DEPTH, then a single pop releases one fetch
    do_redirect(32'h0);
    addr_log.delete();
    repeat (40) step();
    check("t2_nfetch", addr_log.size(), 4);
    check("t2_addr3", log_at(3), 32'hC);
    check("t2_cyc", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    check("t2_empty", {31'h0, empty_o}, 32'h0);
    check("t2_head", out_pc_o, 32'h0);
    push_exp(32'h0, 32'hA5A5_0000, 1'b0, 32'h0);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    repeat (10) step();
    check("t2_nfetch2", addr_log.size(), 5);
    check("t2_addr4", log_at(4), 32'h10);
    check("t2_cyc2", {31'h0, bus.iwbm_cyc_o}, 32'h0);

    // redirect while a slow transfer is pending
    lat    = 3;
    ovr_en = 1'b1;
    do_redirect(32'h300);
    addr_log.delete();
    wait_cyc(1'b1, "t3_issue");
    check("t3_addr", bus.iwbm_addr_o, 32'h300);
    do_redirect(32'h100);
    check("t3_held", {31'h0, bus.iwbm_cyc_o}, 32'h1);
    check("t3_flush", {31'h0, out_valid_o}, 32'h0);
    wait_cyc(1'b0, "t3_drop");
    ovr_en = 1'b0;
    check("t3_empty", {31'h0, empty_o}, 32'h1);
    wait_cyc(1'b1, "t3_reissue");
    check("t3_addr2", bus.iwbm_addr_o, 32'h100);
    push_exp(32'h100, 32'hA5A5_0100, 1'b0, 32'h0);
    out_ready_i = 1'b1;
    wait_drain("t3_drain");
    out_ready_i = 1'b0;
    lat = 1;
    repeat (40) step();

    // ack and redirect in the same cycle
    resp_en = 1'b0;
    check("t4_full_cyc", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    do_redirect(32'h500);
    wait_cyc(1'b1, "t4_issue");
    check("t4_addr", bus.iwbm_addr_o, 32'h500);
    bus.iwbm_dat_i  = 32'h1234_5678;
    bus.iwbm_ack_i  = 1'b1;
    redirect_addr_i = 32'h200;
    redirect_i      = 1'b1;
    step();
    bus.iwbm_ack_i  = 1'b0;
    redirect_i      = 1'b0;
    check("t4_cyc", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    check("t4_valid", {31'h0, out_valid_o}, 32'h0);
    wait_cyc(1'b1, "t4_reissue");
    check("t4_addr2", bus.iwbm_addr_o, 32'h200);
    check("t4_empty", {31'h0, empty_o}, 32'h1);

    // bus error at 0x40 locks fetch until redirect
    do_redirect(32'h40);
    check("t5_disc", {31'h0, bus.iwbm_cyc_o}, 32'h1);
    bus.iwbm_ack_i = 1'b1;
    step();
    bus.iwbm_ack_i = 1'b0;
    check("t5_disc_end", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    wait_cyc(1'b1, "t5_issue");
    check("t5_addr", bus.iwbm_addr_o, 32'h40);
    push_exp(32'h40, 32'h0, 1'b1, 32'h40);
    out_ready_i    = 1'b1;
    bus.iwbm_err_i = 1'b1;
    step();
    bus.iwbm_err_i = 1'b0;
    repeat (6) step();
    check("t5_locked", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    check("t5_popped", exp_q.size(), 0);
    do_redirect(32'h80);
    wait_cyc(1'b1, "t5_reissue");
    check("t5_addr2", bus.iwbm_addr_o, 32'h80);
    push_exp(32'h80, 32'hCAFE_0080, 1'b0, 32'h0);
    bus.iwbm_dat_i = 32'hCAFE_0080;
    bus.iwbm_ack_i = 1'b1;
    step();
    bus.iwbm_ack_i = 1'b0;
    wait_drain("t5_drain");
    out_ready_i = 1'b0;

    // reset in the middle of an open cycle, late ack ignored
    wait_cyc(1'b1, "t6_issue");
    check("t6_addr", bus.iwbm_addr_o, 32'h84);
    rst_i = 1'b0;
    step();
    check("t6_cyc", {31'h0, bus.iwbm_cyc_o}, 32'h0);
    check("t6_stb", {31'h0, bus.iwbm_stb_o}, 32'h0);
    check("t6_valid", {31'h0, out_valid_o}, 32'h0);
    check("t6_addr_rst", bus.iwbm_addr_o, 32'h0);
    rst_i          = 1'b1;
    bus.iwbm_dat_i = 32'hBAD0_BAD0;
    bus.iwbm_ack_i = 1'b1;
    step();
    bus.iwbm_ack_i = 1'b0;
    check("t6_noval", {31'h0, out_valid_o}, 32'h0);
    check("t6_empty", {31'h0, empty_o}, 32'h1);
    check("t6_reissue", {31'h0, bus.iwbm_cyc_o}, 32'h1);
    check("t6_addr2", bus.iwbm_addr_o, 32'h0);
    push_exp(32'h0, 32'h1111_0000, 1'b0, 32'h0);
    out_ready_i    = 1'b1;
    bus.iwbm_dat_i = 32'h1111_0000;
    bus.iwbm_ack_i = 1'b1;
    step();
    bus.iwbm_ack_i = 1'b0;
    wait_drain("t6_drain");
    out_ready_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
